mult_sequencer: RTL and testbench
=================================

MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 The block SHALL have the parameter ITER, default 32, meaning the number of Booth iterations per multiply.
REQ-002 The block SHALL have the port clock, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have the port ctrl_MULT, input, 1 bit: a single-cycle start pulse.
REQ-005 The block SHALL have the port data_operandA, input, 32 bits: the signed multiplicand, sampled at start.
REQ-006 The block SHALL have the port data_operandB, input, 32 bits: the signed multiplier, sampled at start.
REQ-007 The block SHALL have the port data_result, output, 32 bits: the low 32 bits of the signed product.
REQ-008 The block SHALL have the port data_exception, output, 1 bit: set when the product does not fit in 32 signed bits.
REQ-009 The block SHALL have the port data_resultRDY, output, 1 bit: a one-cycle completion pulse.
REQ-010 The block SHALL have the port busy, output, 1 bit: high while not IDLE.
REQ-011 The block SHALL have the port alu_operandA, output, 32 bits: driven to the shared combinational ALU.
REQ-012 The block SHALL have the port alu_operandB, output, 32 bits: driven to the shared ALU.
REQ-013 The block SHALL have the port alu_opcode, output, 5 bits: 00000 = add, 00001 = subtract.
REQ-014 The block SHALL have the port alu_shiftamt, output, 5 bits: held at 0.
REQ-015 The block SHALL have the port alu_result, input, 32 bits: the ALU result, valid in the same cycle.
REQ-016 The block SHALL have the port alu_overflow, input, 1 bit: the ALU add/subtract overflow flag, valid in the same cycle.

Function
REQ-017 The block SHALL implement the states IDLE, RUN and DONE, encoded in registers.
REQ-018 IDLE -> RUN SHALL occur on a clock edge where ctrl_MULT=1: M <= data_operandA, ACC <= 0, Q <= data_operandB, q_m1 <= 0, count <= 0.
REQ-019 ctrl_MULT SHALL be ignored in RUN and DONE, with no restart and no change to the latched operands.
REQ-020 In RUN, the ALU drive SHALL be alu_operandA=ACC and alu_operandB=M on every cycle; the drive SHALL be combinational from the registers.
REQ-021 In RUN, {Q[0],q_m1}=10 SHALL select opcode 00001; all other values of the pair SHALL select 00000.
REQ-022 In RUN, the new accumulator value SHALL be: S = alu_result for 01/10; S = ACC for 00/11, in which case the ALU result is discarded.
REQ-023 The true sign bit T SHALL be alu_result[31] XOR alu_overflow for 01/10, and ACC[31] otherwise.
REQ-024 Each RUN edge SHALL perform a 65-bit arithmetic right shift: {ACC,Q,q_m1} <= {T,S,Q}, and count <= count+1.
REQ-025 RUN -> DONE SHALL occur on the edge where count reaches ITER-1, i.e. after exactly ITER RUN cycles.
REQ-026 In DONE, data_resultRDY SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE on the next edge.
REQ-027 data_result SHALL equal Q whenever Q is valid and SHALL hold its value in IDLE until the next start.
REQ-028 data_exception SHALL be 1 iff ACC is not all copies of Q[31], evaluated on the final product and held with data_result.
REQ-029 Latency SHALL be: start edge at cycle 0, RUN cycles 1..ITER, data_resultRDY high in cycle ITER+1 (cycle 33 at default).
REQ-030 A start pulse in the same cycle as DONE SHALL be ignored; a start in the first IDLE cycle after DONE SHALL be accepted.
REQ-031 In IDLE and DONE, the ALU outputs SHALL be alu_operandA=0, alu_operandB=0, alu_opcode=00000.
REQ-032 Operand -2^31 as M SHALL be handled correctly via T, with no dependence on 33-bit ALU width.

Reset
REQ-033 While reset=1, state, ACC, Q, M, q_m1 and count SHALL be 0 and state SHALL be IDLE, independent of clock.
REQ-034 After reset, data_result SHALL be 0, data_exception 0, data_resultRDY 0 and busy 0.
REQ-035 Reset asserted during RUN or DONE SHALL abort the operation immediately with no data_resultRDY pulse; a start after deassertion SHALL behave normally.

Verification
REQ-036 Scenario 1: A=3, B=5, start -> data_resultRDY exactly 33 cycles after the start edge, data_result=15, data_exception=0.
REQ-037 Scenario 2: A=-7, B=6 -> data_result=0xFFFFFFD6 (-42), data_exception=0; A=0x80000000, B=1 -> 0x80000000, data_exception=0.
REQ-038 Scenario 3: A=0x7FFFFFFF, B=2 -> data_result=0xFFFFFFFE, data_exception=1; A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, data_exception=1.
REQ-039 Scenario 4: a second ctrl_MULT pulse at cycle 10 with different operands -> the first result is unchanged and the second operation is not started; busy stays 1 through cycle 33.
REQ-040 Scenario 5: reset pulse at cycle 15 of RUN -> busy=0 at once, no data_resultRDY pulse; a new start of 4*4 -> 16 after 33 cycles.
REQ-041 Scenario 6: an opcode monitor over 1000 random signed operand pairs -> alu_opcode is only 00000 or 00001 in RUN, and the result and exception match a 64-bit reference model.

Source files
------------

// File: rtl/mult_sequencer.sv
// mult_sequencer: radix-2 Booth multiply sequencer driving a shared
// combinational ALU. One add/subtract per cycle over ITER cycles produces a
// 64-bit product in {ACC,Q}; the low word is returned along with an overflow
// flag for products that do not fit in 32 signed bits.
//
// State table:
//   IDLE | waiting for ctrl_MULT; result/exception hold the last product
//   RUN  | one Booth step per cycle, ITER cycles total
//   DONE | data_resultRDY high for this one cycle, then back to IDLE
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   ctrl_MULT           start pulse, accepted only in IDLE
//   data_operandA/B     signed multiplicand / multiplier, sampled at start
//   data_result         low 32 bits of the product (tracks Q)
//   data_exception      product does not fit in 32 signed bits
//   data_resultRDY      one-cycle completion pulse
//   busy                high while not IDLE
//   alu_operandA/B      ALU inputs (ACC and M during RUN, zero otherwise)
//   alu_opcode          00000 add, 00001 subtract
//   alu_shiftamt        always zero
//   alu_result          ALU sum/difference, same cycle
//   alu_overflow        ALU signed overflow, same cycle
module mult_sequencer #(
  parameter int ITER = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  output logic [4:0]  alu_opcode,
  output logic [4:0]  alu_shiftamt,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [31:0]     acc_q;
  logic [31:0]     q_q;
  logic [31:0]     m_q;
  logic            qm1_q;
  logic [CW-1:0]   count_q;

  logic            use_alu;
  logic [31:0]     sum_s;
  logic            sign_t;

  // Booth pair 01 adds M, 10 subtracts M; 00/11 keep ACC unchanged.
  assign use_alu = q_q[0] ^ qm1_q;

  always_comb begin
    alu_operandA = 32'd0;
    alu_operandB = 32'd0;
    alu_opcode   = 5'b00000;
    if (state_q == RUN) begin
      alu_operandA = acc_q;
      alu_operandB = m_q;
      if (q_q[0] && !qm1_q) begin
        alu_opcode = 5'b00001;
      end
    end
  end

  assign alu_shiftamt = 5'd0;

  // The shifted-in sign must be the sign of the exact 33-bit sum, which the
  // 32-bit ALU loses on overflow (e.g. ACC - (-2^31)); XOR with overflow
  // recovers it without a wider adder.
  always_comb begin
    sum_s  = acc_q;
    sign_t = acc_q[31];
    if (use_alu) begin
      sum_s  = alu_result;
      sign_t = alu_result[31] ^ alu_overflow;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= 32'd0;
      q_q     <= 32'd0;
      m_q     <= 32'd0;
      qm1_q   <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ctrl_MULT) begin
            m_q     <= data_operandA;
            acc_q   <= 32'd0;
            q_q     <= data_operandB;
            qm1_q   <= 1'b0;
            count_q <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= {sign_t, sum_s[31:1]};
          q_q     <= {sum_s[0], q_q[31:1]};
          qm1_q   <= q_q[0];
          count_q <= count_q + CW'(1);
          if (count_q == CW'(ITER - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_result    = q_q;
  assign data_exception = (acc_q != {32{q_q[31]}});
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mult_sequencer.sv
module tb_mult_sequencer;

  localparam int ITER = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
  logic [31:0] alu_operandA;
  logic [31:0] alu_operandB;
  logic [4:0]  alu_opcode;
  logic [4:0]  alu_shiftamt;
  logic [31:0] alu_result;
  logic        alu_overflow;

  mult_sequencer #(.ITER(ITER)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .alu_operandA   (alu_operandA),
    .alu_operandB   (alu_operandB),
    .alu_opcode     (alu_opcode),
    .alu_shiftamt   (alu_shiftamt),
    .alu_result     (alu_result),
    .alu_overflow   (alu_overflow)
  );

  always #5 clock = ~clock;

  // Shared combinational ALU
  always_comb begin
    alu_result   = 32'd0;
    alu_overflow = 1'b0;
    if (alu_opcode == 5'b00001) begin
      alu_result   = alu_operandA - alu_operandB;
      alu_overflow = (alu_operandA[31] != alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
    end else begin
      alu_result   = alu_operandA + alu_operandB;
      alu_overflow = (alu_operandA[31] == alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  logic        mon_en = 1'b0;
  logic [31:0] last_r;
  logic        last_e;

  // Monitor: ALU drive legality every cycle, result scoreboard on RDY
  always @(negedge clock) begin
    if (mon_en) begin
      n_vec++;
      if (busy && !data_resultRDY) begin
        if (alu_opcode > 5'd1 || alu_shiftamt != 5'd0) begin
          n_err++;
          $display("FAIL alu_run cyc=%0d opcode=%b shamt=%0d required opcode<=1 shamt=0", cyc, alu_opcode, alu_shiftamt);
        end
      end else begin
        if (alu_operandA != 0 || alu_operandB != 0 || alu_opcode != 0 || alu_shiftamt != 0) begin
          n_err++;
          $display("FAIL alu_idle cyc=%0d A=%h B=%h op=%b shamt=%0d required all zero", cyc, alu_operandA, alu_operandB, alu_opcode, alu_shiftamt);
        end
      end
      if (data_resultRDY) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_rdy cyc=%0d result=%h required no pulse", cyc, data_result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          n_vec += 3;
          if (data_result != e.res) begin
            n_err++;
            $display("FAIL result cyc=%0d got=%h exp=%h", cyc, data_result, e.res);
          end
          if (data_exception != e.exc) begin
            n_err++;
            $display("FAIL exception cyc=%0d got=%b exp=%b (result exp=%h)", cyc, data_exception, e.exc, e.res);
          end
          if (cyc != e.done_cyc) begin
            n_err++;
            $display("FAIL latency rdy_cyc=%0d exp_cyc=%0d", cyc, e.done_cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  // Issue a start pulse; start_c is the cycle count while ctrl_MULT is high,
  // so the completion pulse is expected ITER+1 cycles later.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic e, output int start_c);
    @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    start_c       = cyc;
    sb.push_back('{r, e, cyc + ITER + 1});
    last_r = r;
    last_e = e;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    data_operandA = ~a;
    data_operandB = 32'h5A5A_A5A5;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL timeout cyc=%0d pending=%0d", cyc, sb.size());
      sb.delete();
    end
    @(negedge clock);
    @(negedge clock);
    check("hold_result", data_result, last_r);
    check("hold_exception", {31'd0, data_exception}, {31'd0, last_e});
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
    longint sa, sb_, p, lo;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    p  = sa * sb_;
    r  = p[31:0];
    lo = longint'($signed(r));
    e  = (p != lo);
  endfunction

  initial begin
    int c;
    logic [31:0] a, b, r;
    logic e;

    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (3) @(negedge clock);
    check("rst_result", data_result, 32'd0);
    check("rst_exception", {31'd0, data_exception}, 32'd0);
    check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clock);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // Directed products
    start_op(32'd3, 32'd5, 32'd15, 1'b0, c);                      wait_done();
    start_op(32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0, c);       wait_done();
    start_op(32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, c);       wait_done();
    start_op(32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1, c);       wait_done();
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, c); wait_done();
    start_op(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, c);       wait_done();
    start_op(32'd0, 32'h8000_0000, 32'd0, 1'b0, c);               wait_done();
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, c);       wait_done();

    // Second start during RUN is ignored; busy holds through DONE
    start_op(32'd5, 32'd7, 32'd35, 1'b0, c);
    for (int k = 1; k <= ITER + 1; k++) begin
      wait_until(c + k);
      if (k == 10) begin
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd100;
      end
      if (k == 11) ctrl_MULT = 1'b0;
      check("busy_hold", {31'd0, busy}, 32'd1);
    end
    wait_done();

    // Start held over DONE: ignored in DONE, accepted in the following IDLE cycle
    start_op(32'd6, 32'd9, 32'd54, 1'b0, c);
    wait_until(c + ITER + 1);
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd12;
    data_operandB = 32'hFFFF_FFFD;
    @(negedge clock);
    sb.push_back('{32'hFFFF_FFDC, 1'b0, cyc + ITER + 1});
    last_r = 32'hFFFF_FFDC;
    last_e = 1'b0;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    wait_done();

    // Reset in the middle of RUN aborts with no completion pulse
    start_op(32'd9, 32'd9, 32'd81, 1'b0, c);
    wait_until(c + 15);
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("abort_result", data_result, 32'd0);
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    wait_until(c + 45);
    check("abort_idle_busy", {31'd0, busy}, 32'd0);
    start_op(32'd4, 32'd4, 32'd16, 1'b0, c);
    wait_done();

    // Random operands against a 64-bit reference product
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) b = {{24{b[7]}}, b[7:0]};
      if (i % 4 == 2) a = {{20{a[11]}}, a[11:0]};
      if (i % 50 == 3) a = 32'h8000_0000;
      ref_mul(a, b, r, e);
      start_op(a, b, r, e, c);
      wait_done();
    end

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
